// File: rtl/ifetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_queue
//
// Instruction-fetch front end that sits directly ahead of decode. It owns the
// fetch PC and drives a single-outstanding-request instruction bus. Returned
// words are buffered together with their PCs in a small FIFO, and the FIFO
// head is presented to the core over a valid/ready handshake. A redirect from
// the core replaces the fetch PC and flushes the FIFO. Any fetch that is
// already in flight is completed on the bus, but its data is discarded.
//
// Parameters
//   PC_INIT  fetch PC loaded on reset
//   DEPTH    FIFO entries (power of two, >= 2)
//
// Ports
//   clk             clock; all state updates on the rising edge
//   reset           synchronous, active-low reset
//   ireq_valid      bus request valid (registered)
//   ireq_addr       bus request address (registered)
//   iresp_addr_ok   bus accepted the request address
//   iresp_data_ok   bus is returning data this cycle
//   iresp_data      returned instruction word
//   inst_valid      FIFO head is valid
//   inst            FIFO head instruction
//   inst_pc         FIFO head PC
//   inst_ready      core consumes the head this cycle
//   redirect_valid  flush and refetch from redirect_pc
//   redirect_pc     new fetch PC; bits [1:0] are forced to zero
// ----------------------------------------------------------------------------
module ifetch_queue #(
  parameter logic [63:0] PC_INIT = 64'h0000_0000_8000_0000,
  parameter int          DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Redirect targets are word aligned; every bit is read so that none of the
  // input is left dangling.
  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return pc & ~64'h3;
  endfunction

  // Sequential fetch address; wraps modulo 2^64.
  function automatic logic [63:0] next_seq_pc(input logic [63:0] pc);
    return pc + 64'd4;
  endfunction

  state_t             state;
  state_t             state_nxt;
  logic [63:0]        fetch_pc;
  logic [63:0]        fetch_pc_nxt;
  logic [63:0]        req_addr;
  logic               drop;
  logic               drop_nxt;
  logic               load_req;
  logic               push;
  logic               pop;
  logic               flush;
  logic               room;
  logic [63:0]        redirect_target;

  logic [31:0]        mem_inst [DEPTH];
  logic [63:0]        mem_pc   [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_after_pop;

  assign redirect_target = align_pc(redirect_pc);
  assign flush           = redirect_valid;

  assign inst_valid = (count != '0);
  assign inst       = mem_inst[rd_ptr];
  assign inst_pc    = mem_pc[rd_ptr];
  assign ireq_addr  = req_addr;

  assign pop = inst_valid & inst_ready;

  // A request is only launched when a slot is guaranteed for its data. Pops
  // during the transaction can only free more space, so a push can never find
  // the FIFO full. pop implies count >= 1, so this never underflows.
  assign count_after_pop = count - CNT_W'(pop);
  assign room            = (count_after_pop < CNT_W'(DEPTH));

  // --------------------------------------------------------------------------
  // Fetch control: next state, next fetch PC, drop flag, push/launch strobes.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    drop_nxt     = drop;
    load_req     = 1'b0;
    push         = 1'b0;

    case (state)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_nxt = redirect_target;
        end else if (room) begin
          load_req  = 1'b1;
          drop_nxt  = 1'b0;
          state_nxt = REQ;
        end
      end

      REQ: begin
        // The bus requires valid/addr to stay up until addr_ok, so a redirect
        // here only marks the in-flight request as stale.
        if (redirect_valid) begin
          fetch_pc_nxt = redirect_target;
          drop_nxt     = 1'b1;
        end
        if (iresp_addr_ok) begin
          if (drop || redirect_valid) begin
            state_nxt = iresp_data_ok ? IDLE : DRAIN;
          end else if (iresp_data_ok) begin
            push         = 1'b1;
            fetch_pc_nxt = next_seq_pc(fetch_pc);
            state_nxt    = IDLE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end

      WAIT: begin
        if (redirect_valid) begin
          fetch_pc_nxt = redirect_target;
          state_nxt    = iresp_data_ok ? IDLE : DRAIN;
        end else if (iresp_data_ok) begin
          push         = 1'b1;
          fetch_pc_nxt = next_seq_pc(fetch_pc);
          state_nxt    = IDLE;
        end
      end

      DRAIN: begin
        if (redirect_valid) begin
          fetch_pc_nxt = redirect_target;
        end
        if (iresp_data_ok) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Fetch control registers and registered bus request outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      fetch_pc   <= PC_INIT;
      req_addr   <= '0;
      drop       <= 1'b0;
      ireq_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      drop       <= drop_nxt;
      ireq_valid <= (state_nxt == REQ);
      if (load_req) begin
        req_addr <= fetch_pc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Instruction FIFO. A flush overrides both push and pop.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem_inst[wr_ptr] <= iresp_data;
        mem_pc[wr_ptr]   <= req_addr;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// ----------------------------------------------------------------------------
// tb_ifetch_queue
//
// Directed scenarios plus a long randomized run for ifetch_queue. The
// reference model tracks fetch transactions by redirect epoch: a returned
// word is kept only if no redirect has occurred since its request was issued.
// ----------------------------------------------------------------------------
module tb_ifetch_queue;

  localparam logic [63:0] PC_INIT = 64'h0000_0000_8000_0000;
  localparam int          DEPTH   = 2;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  int errors = 0;
  int checks = 0;

  ifetch_queue #(.PC_INIT(PC_INIT), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_addr_ok  (iresp_addr_ok),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] word;
    logic [63:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_fpc;
  logic [63:0] m_addr;
  logic [63:0] tx_addr;
  bit          tx_live;
  bit          tx_acc;
  int          m_ep;
  int          tx_ep;
  bit          m_reqv;
  bit          m_valid;
  ent_t        m_head;

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_update();
    bit   pop;
    bit   room;
    bit   data_now;
    ent_t e;
    if (!reset) begin
      mq.delete();
      m_fpc   = PC_INIT;
      m_addr  = '0;
      tx_live = 0;
      tx_acc  = 0;
      m_ep    = 0;
      tx_ep   = 0;
    end else begin
      pop      = (mq.size() != 0) && inst_ready;
      room     = (mq.size() - int'(pop)) < DEPTH;
      data_now = tx_live && (tx_acc || iresp_addr_ok) && iresp_data_ok;
      if (redirect_valid) begin
        m_ep++;
        m_fpc = redirect_pc & ~64'h3;
        mq.delete();
      end else if (pop) begin
        void'(mq.pop_front());
      end
      if (data_now) begin
        if (tx_ep == m_ep) begin
          e.word = iresp_data;
          e.pc   = tx_addr;
          mq.push_back(e);
          m_fpc = tx_addr + 64'd4;
        end
        tx_live = 0;
      end else if (tx_live) begin
        if (iresp_addr_ok) tx_acc = 1;
      end else if (!redirect_valid && room) begin
        tx_live = 1;
        tx_acc  = 0;
        tx_addr = m_fpc;
        tx_ep   = m_ep;
        m_addr  = m_fpc;
      end
    end
    m_reqv  = tx_live && !tx_acc;
    m_valid = (mq.size() != 0);
    if (m_valid) m_head = mq[0];
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    iresp_addr_ok  = 1'b0;
    iresp_data_ok  = 1'b0;
    iresp_data     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  // Leaves reset deasserted; the next step() is the release edge.
  task automatic do_reset();
    quiet();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    quiet();
    inst_ready = 1'b0;
    reset      = 1'b0;
    step();
    step();
    checks++;
    if ({ireq_valid, inst_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_valid: got ireq_valid=%b inst_valid=%b want 0 0", ireq_valid, inst_valid);
    end
    checks++;
    if (ireq_addr !== 64'h0) begin
      errors++;
      $display("FAIL reset_addr: got %h want 0", ireq_addr);
    end
    checks++;
    if ({inst, inst_pc} !== 96'h0) begin
      errors++;
      $display("FAIL reset_head: got inst=%h pc=%h want 0 0", inst, inst_pc);
    end
  endtask

  task automatic test_zero_wait();
    logic [63:0] req_seen[$];
    logic [63:0] pop_seen[$];
    logic [63:0] exp_seq [3];
    logic [63:0] got;
    exp_seq[0] = 64'h8000_0000;
    exp_seq[1] = 64'h8000_0004;
    exp_seq[2] = 64'h8000_0008;
    do_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (inst_valid && inst_ready) pop_seen.push_back(inst_pc);
      iresp_addr_ok = m_reqv;
      iresp_data_ok = m_reqv;
      iresp_data    = $urandom;
      step();
      if (ireq_valid) req_seen.push_back(ireq_addr);
      checks++;
      if (ireq_valid !== m_reqv || ireq_addr !== m_addr || inst_valid !== m_valid) begin
        errors++;
        $display("FAIL zw_ctl cyc %0d: got v=%b a=%h iv=%b want v=%b a=%h iv=%b",
                 i, ireq_valid, ireq_addr, inst_valid, m_reqv, m_addr, m_valid);
      end
      if (m_valid) begin
        checks++;
        if ({inst, inst_pc} !== m_head) begin
          errors++;
          $display("FAIL zw_head cyc %0d: got %h/%h want %h/%h", i, inst, inst_pc, m_head.word, m_head.pc);
        end
      end
    end
    checks++;
    if (req_seen.size() != 7) begin
      errors++;
      $display("FAIL zw_rate: got %0d requests in 14 cycles want 7", req_seen.size());
    end
    for (int k = 0; k < 3; k++) begin
      got = (k < req_seen.size()) ? req_seen[k] : 64'hx;
      checks++;
      if (got !== exp_seq[k]) begin
        errors++;
        $display("FAIL zw_req_addr %0d: got %h want %h", k, got, exp_seq[k]);
      end
      got = (k < pop_seen.size()) ? pop_seen[k] : 64'hx;
      checks++;
      if (got !== exp_seq[k]) begin
        errors++;
        $display("FAIL zw_inst_pc %0d: got %h want %h", k, got, exp_seq[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int nreq;
    nreq = 0;
    do_reset();
    inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      iresp_addr_ok = m_reqv;
      iresp_data_ok = m_reqv;
      iresp_data    = $urandom;
      step();
      if (ireq_valid) nreq++;
    end
    checks++;
    if (nreq != 2 || ireq_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_fetches: got %0d requests, ireq_valid=%b want 2, 0", nreq, ireq_valid);
    end
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 64'h8000_0000) begin
      errors++;
      $display("FAIL bp_head: got iv=%b pc=%h want 1 80000000", inst_valid, inst_pc);
    end
    quiet();
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0008) begin
      errors++;
      $display("FAIL bp_refetch: got v=%b a=%h want 1 80000008", ireq_valid, ireq_addr);
    end
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 64'h8000_0004 || {inst, inst_pc} !== m_head) begin
      errors++;
      $display("FAIL bp_next_head: got iv=%b %h/%h want 1 %h/80000004", inst_valid, inst, inst_pc, m_head.word);
    end
  endtask

  task automatic test_addr_delay();
    do_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ireq_valid !== 1'b1 || ireq_addr !== PC_INIT) begin
        errors++;
        $display("FAIL ad_hold %0d: got v=%b a=%h want 1 %h", i, ireq_valid, ireq_addr, PC_INIT);
      end
    end
    iresp_addr_ok = 1'b1;
    step();
    quiet();
    checks++;
    if (ireq_valid !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL ad_accept: got v=%b iv=%b want 0 0", ireq_valid, inst_valid);
    end
    step();
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h1234_5678;
    step();
    quiet();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== PC_INIT || inst !== 32'h1234_5678) begin
      errors++;
      $display("FAIL ad_data: got iv=%b %h/%h want 1 12345678/%h", inst_valid, inst, inst_pc, PC_INIT);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    inst_ready = 1'b1;
    step();
    iresp_addr_ok = 1'b1;
    step();
    quiet();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1002;
    step();
    quiet();
    step();
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hDEAD_BEEF;
    step();
    quiet();
    checks++;
    if (inst_valid !== 1'b0 || ireq_valid !== 1'b0) begin
      errors++;
      $display("FAIL rw_drop: got iv=%b v=%b want 0 0", inst_valid, ireq_valid);
    end
    step();
    checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_1000) begin
      errors++;
      $display("FAIL rw_target: got v=%b a=%h want 1 80001000", ireq_valid, ireq_addr);
    end
    iresp_addr_ok = 1'b1;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h3333_3333;
    step();
    quiet();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 64'h8000_1000 || inst !== 32'h3333_3333) begin
      errors++;
      $display("FAIL rw_first: got iv=%b %h/%h want 1 33333333/80001000", inst_valid, inst, inst_pc);
    end
  endtask

  task automatic test_redirect_pop();
    do_reset();
    inst_ready = 1'b0;
    step();
    iresp_addr_ok = 1'b1;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h1111_1111;
    step();
    quiet();
    step();
    iresp_addr_ok = 1'b1;
    step();
    quiet();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 64'h8000_0000 || ireq_valid !== 1'b0) begin
      errors++;
      $display("FAIL rp_setup: got iv=%b pc=%h v=%b want 1 80000000 0", inst_valid, inst_pc, ireq_valid);
    end
    iresp_data_ok  = 1'b1;
    iresp_data     = 32'h2222_2222;
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h9000_0000;
    step();
    quiet();
    inst_ready = 1'b0;
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rp_flush: got iv=%b want 0", inst_valid);
    end
    step();
    checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 64'h9000_0000 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rp_target: got v=%b a=%h iv=%b want 1 90000000 0", ireq_valid, ireq_addr, inst_valid);
    end
  endtask

  task automatic test_reset_wait();
    do_reset();
    inst_ready = 1'b1;
    step();
    iresp_addr_ok = 1'b1;
    step();
    quiet();
    reset = 1'b0;
    step();
    checks++;
    if ({ireq_valid, inst_valid} !== 2'b00 || ireq_addr !== 64'h0 || {inst, inst_pc} !== 96'h0) begin
      errors++;
      $display("FAIL rst_wait_outputs: got v=%b a=%h iv=%b %h/%h want all 0",
               ireq_valid, ireq_addr, inst_valid, inst, inst_pc);
    end
    reset         = 1'b1;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hCAFE_F00D;
    step();
    quiet();
    checks++;
    if (inst_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== PC_INIT) begin
      errors++;
      $display("FAIL rst_wait_stray: got iv=%b v=%b a=%h want 0 1 %h", inst_valid, ireq_valid, ireq_addr, PC_INIT);
    end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    quiet();
    checks++;
    if (ireq_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_idle: got v=%b want 0", ireq_valid);
    end
    step();
    checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_req: got v=%b a=%h want 1 fffffffffffffffc", ireq_valid, ireq_addr);
    end
    iresp_addr_ok = 1'b1;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h4444_4444;
    step();
    quiet();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_head: got iv=%b pc=%h want 1 fffffffffffffffc", inst_valid, inst_pc);
    end
    step();
    checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 64'h0) begin
      errors++;
      $display("FAIL wrap_next: got v=%b a=%h want 1 0", ireq_valid, ireq_addr);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset          = ($urandom_range(0, 299) != 0);
      inst_ready     = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = {$urandom, $urandom};
      iresp_addr_ok  = m_reqv && ($urandom_range(0, 1) == 1);
      iresp_data_ok  = tx_live && (tx_acc || iresp_addr_ok) && ($urandom_range(0, 1) == 1);
      iresp_data     = $urandom;
      step();
      checks++;
      if (ireq_valid !== m_reqv || ireq_addr !== m_addr || inst_valid !== m_valid) begin
        errors++;
        $display("FAIL rand_ctl cyc %0d: got v=%b a=%h iv=%b want v=%b a=%h iv=%b",
                 i, ireq_valid, ireq_addr, inst_valid, m_reqv, m_addr, m_valid);
      end
      if (m_valid) begin
        checks++;
        if ({inst, inst_pc} !== m_head) begin
          errors++;
          $display("FAIL rand_head cyc %0d: got %h/%h want %h/%h", i, inst, inst_pc, m_head.word, m_head.pc);
        end
      end
    end
    quiet();
  endtask

  initial begin
    reset      = 1'b0;
    inst_ready = 1'b0;
    quiet();
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_addr_delay();
    test_redirect_wait();
    test_redirect_pop();
    test_reset_wait();
    test_pc_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion within time limit, want completion");
    $fatal(1);
  end

endmodule
